modmul_feeder: RTL
==================

// Module: modmul_feeder
// PURPOSE
//   Upstream stage of barrett_pipelined for modular multiplication.
//   - Accepts operand pairs (a,b) over a valid/ready handshake into a small FIFO.
//   - Multiplies them in a MUL_STAGES-deep pipelined multiplier.
//   - Drives x_o / start_o straight into barrett_pipelined.x_i / start_i.
//   - barrett_pipelined has no backpressure, so flow is controlled here (hold_i).
// PARAMETERS
//   OP_WIDTH    32  operand width; x_o is 2*OP_WIDTH (= DATA_LENGTH)
//   FIFO_DEPTH  4   operand FIFO entries, power of two, >=2
//   MUL_STAGES  2   multiplier pipeline registers, >=1
// PORTS
//   clk_i        in   1           rising-edge clock
//   rst_ni       in   1           asynchronous active-low reset
//   in_valid_i   in   1           operand pair valid
//   in_ready_o   out  1           FIFO can accept a pair this cycle
//   a_i          in   OP_WIDTH    operand a
//   b_i          in   OP_WIDTH    operand b
//   hold_i       in   1           1: do not issue new pairs from FIFO into the multiplier
//   x_o          out  2*OP_WIDTH  product a*b, to barrett x_i
//   start_o      out  1           x_o valid this cycle, to barrett start_i
//   busy_o       out  1           FIFO non-empty or any multiplier stage valid
//   count_o      out  $clog2(FIFO_DEPTH)+1  current FIFO occupancy
// BEHAVIOUR
//   - Reset (async, rst_ni=0):
//     - FIFO pointers and count cleared; all stage valid bits cleared.
//     - x_o=0, start_o=0, busy_o=0, count_o=0, in_ready_o=1.
//     - Reset mid-operation discards all in-flight and queued pairs.
//   - Handshake:
//     - push = in_valid_i & in_ready_o.
//     - in_ready_o = (count<FIFO_DEPTH) | pop; it depends on pop, not on in_valid_i.
//     - A push while full is legal only when a pop happens in the same cycle.
//   - Issue:
//     - pop = (count!=0) & ~hold_i.
//     - The popped entry enters multiplier stage 1 with valid=1; otherwise stage 1 valid=0.
//     - The multiplier pipeline never stalls; hold_i only gates issue, in-flight data still drains.
//   - Occupancy:
//     - count += push - pop; simultaneous push+pop leaves count unchanged.
//     - Pointers wrap modulo FIFO_DEPTH.
//     - An empty FIFO with push: the entry cannot pop in the same cycle (no fall-through).
//   - Latency:
//     - A pair pushed at edge t may pop at edge t+1.
//     - x_o/start_o are registered and valid at edge t+1+MUL_STAGES (default 3 cycles).
//     - Throughput is 1 pair/cycle.
//   - Arithmetic:
//     - Unsigned OP_WIDTH x OP_WIDTH -> 2*OP_WIDTH full product, no truncation.
//     - Partial-product split across stages is free; the result must be bit-exact a*b.
//   - Outputs:
//     - start_o is a 1-cycle pulse per pair; back-to-back pairs give consecutive pulses.
//     - x_o holds its last value when start_o=0.
//     - Order is strictly FIFO.
//   - busy_o is combinational from count and the stage valid bits.
// CONFIGURATION
//   MODMUL_FEEDER_BYPASS_EN defined:
//     - Adds input port bypass_i (1 bit), stored per FIFO entry alongside a,b.
//     - Entry with bypass=1: x_o = {OP_WIDTH'0, a}; b is ignored.
//     - Bypass entries keep identical latency, ordering and start_o timing (raw values go to reduction).
//   Undefined:
//     - No bypass_i port; every entry produces a*b.
// TESTING
//   1. Reset: rst_ni=0 with in_valid_i=1 -> start_o=0, count_o=0, in_ready_o=1; no output after release until a new push.
//   2. Single pair: a=0x007FE000, b=0x00000002 pushed at edge 0 -> start_o=1 and x_o=0x0000_0000_00FF_C000 at edge 3.
//   3. Stream: 8 back-to-back pairs a=i+1, b=8380417, hold_i=0 -> 8 consecutive start_o pulses, x_o=(i+1)*8380417, in order.
//   4. Hold/full: hold_i=1, push 5 pairs -> count_o=4 and in_ready_o=0 after the 4th push; release hold_i -> first pop, 5th accepted same cycle, all 5 products in order.
//   5. Max operands: a=b=0xFFFFFFFF -> x_o=0xFFFF_FFFE_0000_0001.
//   6. Async reset mid-stream, 3 pairs in flight -> start_o drops at once, no stale pulse after release.
//   - With MODMUL_FEEDER_BYPASS_EN: bypass_i=1, a=0x1234, b=0x5 -> x_o=0x1234 at the same latency as test 2.

Source files
------------

// File: rtl/modmul_feeder_if.sv
`default_nettype none
// ============================================================================
// Module      : modmul_feeder_if
// Description : Operand/product bus between a producer of operand pairs and
//               modmul_feeder, and between modmul_feeder and the Barrett
//               reducer it feeds.
//               master modport: the side that pushes operands, applies hold
//                               and observes products.
//               slave  modport: modmul_feeder itself.
//   in_valid_i  operand pair valid               (master -> slave)
//   in_ready_o  FIFO can accept a pair           (slave  -> master)
//   a_i, b_i    operands, OP_WIDTH each          (master -> slave)
//   bypass_i    pass a through unmultiplied      (master -> slave, only with
//               MODMUL_FEEDER_BYPASS_EN defined)
//   hold_i      gate issue from FIFO             (master -> slave)
//   x_o         2*OP_WIDTH product               (slave  -> master)
//   start_o     x_o valid pulse                  (slave  -> master)
//   busy_o      work queued or in flight         (slave  -> master)
//   count_o     FIFO occupancy                   (slave  -> master)
// Revision    : 1.0 - initial release
// ============================================================================
interface modmul_feeder_if #(
    parameter int OP_WIDTH   = 32,
    parameter int FIFO_DEPTH = 4
);
    localparam int CW = $clog2(FIFO_DEPTH) + 1;

    logic                  in_valid_i;
    logic                  in_ready_o;
    logic [OP_WIDTH-1:0]   a_i;
    logic [OP_WIDTH-1:0]   b_i;
`ifdef MODMUL_FEEDER_BYPASS_EN
    logic                  bypass_i;
`endif
    logic                  hold_i;
    logic [2*OP_WIDTH-1:0] x_o;
    logic                  start_o;
    logic                  busy_o;
    logic [CW-1:0]         count_o;

    modport master (
`ifdef MODMUL_FEEDER_BYPASS_EN
        output bypass_i,
`endif
        output in_valid_i, a_i, b_i, hold_i,
        input  in_ready_o, x_o, start_o, busy_o, count_o
    );

    modport slave (
`ifdef MODMUL_FEEDER_BYPASS_EN
        input  bypass_i,
`endif
        input  in_valid_i, a_i, b_i, hold_i,
        output in_ready_o, x_o, start_o, busy_o, count_o
    );
endinterface
`default_nettype wire

// File: rtl/modmul_feeder.sv
`default_nettype none
// ============================================================================
// Module      : modmul_feeder
// Description : Front end of the Barrett modular multiplier. Operand pairs
//               are queued in a small FIFO, multiplied in a MUL_STAGES-deep
//               pipelined multiplier and presented as x_o/start_o to the
//               reducer. The reducer cannot backpressure, so hold_i is the
//               only flow control: it stops issue from the FIFO while
//               in-flight products keep draining.
// Ports       : clk_i   rising-edge clock
//               rst_ni  asynchronous active-low reset
//               bus     modmul_feeder_if.slave (operands in, products out,
//                       hold, busy, occupancy)
// Parameters  : OP_WIDTH   operand width, product is 2*OP_WIDTH
//               FIFO_DEPTH operand FIFO entries, power of two, >= 2
//               MUL_STAGES multiplier pipeline registers, >= 1
// Options     : MODMUL_FEEDER_BYPASS_EN - when defined, each FIFO entry
//               carries a bypass flag; a bypass entry yields x_o = {0, a}
//               with the same latency and ordering as a real product.
// Latency     : pair pushed at edge t -> popped at t+1 -> x_o/start_o
//               registered at t+1+MUL_STAGES; 1 pair/cycle throughput.
// Revision    : 1.0 - initial release
// ============================================================================
module modmul_feeder #(
    parameter int OP_WIDTH   = 32,
    parameter int FIFO_DEPTH = 4,
    parameter int MUL_STAGES = 2
) (
    input  wire logic        clk_i,
    input  wire logic        rst_ni,
    modmul_feeder_if.slave   bus
);
    localparam int AW   = $clog2(FIFO_DEPTH);
    localparam int CW   = AW + 1;
    localparam int PW   = 2 * OP_WIDTH;
    // Operands are split into a low and a high half; the four partial
    // products are registered in stage 1 and summed on the way to stage 2.
    localparam int LO_W = OP_WIDTH / 2;
    localparam int HI_W = OP_WIDTH - LO_W;

    localparam logic [CW-1:0] C_DEPTH = CW'(FIFO_DEPTH);

    // ------------------------------------------------------------------
    // Operand FIFO
    // ------------------------------------------------------------------
    logic [OP_WIDTH-1:0] r_mem_a [FIFO_DEPTH];
    logic [OP_WIDTH-1:0] r_mem_b [FIFO_DEPTH];
    logic [AW-1:0]       r_wr_ptr;
    logic [AW-1:0]       r_rd_ptr;
    logic [CW-1:0]       r_count;

    logic                w_pop;
    logic                w_push;
    logic                w_in_ready;
    logic [OP_WIDTH-1:0] w_head_a;
    logic [OP_WIDTH-1:0] w_head_b;

    // Pop only looks at the registered count, so an entry written at this
    // edge cannot leave at the same edge (no fall-through).
    assign w_pop      = (r_count != '0) && !bus.hold_i;
    // Ready may rely on a same-cycle pop to free a slot when full.
    assign w_in_ready = (r_count < C_DEPTH) || w_pop;
    assign w_push     = bus.in_valid_i && w_in_ready;

    assign w_head_a   = r_mem_a[r_rd_ptr];

`ifdef MODMUL_FEEDER_BYPASS_EN
    logic r_mem_byp [FIFO_DEPTH];

    always_ff @(posedge clk_i) begin
        if (w_push) begin
            r_mem_byp[r_wr_ptr] <= bus.bypass_i;
        end
    end

    // A bypass entry is multiplied by one, which gives {0, a} through the
    // unchanged datapath and so keeps latency and ordering identical.
    assign w_head_b = r_mem_byp[r_rd_ptr] ? OP_WIDTH'(1) : r_mem_b[r_rd_ptr];
`else
    assign w_head_b = r_mem_b[r_rd_ptr];
`endif

    // Storage needs no reset: an entry is only read after it was written.
    always_ff @(posedge clk_i) begin
        if (w_push) begin
            r_mem_a[r_wr_ptr] <= bus.a_i;
            r_mem_b[r_wr_ptr] <= bus.b_i;
        end
    end

    // Pointers are AW bits wide and FIFO_DEPTH is a power of two, so the
    // natural overflow implements the modulo wrap.
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            r_wr_ptr <= '0;
            r_rd_ptr <= '0;
            r_count  <= '0;
        end else begin
            if (w_push) begin
                r_wr_ptr <= r_wr_ptr + AW'(1);
            end
            if (w_pop) begin
                r_rd_ptr <= r_rd_ptr + AW'(1);
            end
            case ({w_push, w_pop})
                2'b10:   r_count <= r_count + CW'(1);
                2'b01:   r_count <= r_count - CW'(1);
                default: r_count <= r_count;
            endcase
        end
    end

    // ------------------------------------------------------------------
    // Multiplier stage 1: partial products of the popped pair
    // ------------------------------------------------------------------
    logic [LO_W-1:0] w_a_lo;
    logic [HI_W-1:0] w_a_hi;
    logic [LO_W-1:0] w_b_lo;
    logic [HI_W-1:0] w_b_hi;

    assign w_a_lo = w_head_a[LO_W-1:0];
    assign w_a_hi = w_head_a[OP_WIDTH-1:LO_W];
    assign w_b_lo = w_head_b[LO_W-1:0];
    assign w_b_hi = w_head_b[OP_WIDTH-1:LO_W];

    logic          r_v1;
    logic [PW-1:0] r_pp_ll;
    logic [PW-1:0] r_pp_lh;
    logic [PW-1:0] r_pp_hl;
    logic [PW-1:0] r_pp_hh;

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            r_v1    <= 1'b0;
            r_pp_ll <= '0;
            r_pp_lh <= '0;
            r_pp_hl <= '0;
            r_pp_hh <= '0;
        end else begin
            r_v1 <= w_pop;
            if (w_pop) begin
                r_pp_ll <= PW'(w_a_lo) * PW'(w_b_lo);
                r_pp_lh <= PW'(w_a_lo) * PW'(w_b_hi);
                r_pp_hl <= PW'(w_a_hi) * PW'(w_b_lo);
                r_pp_hh <= PW'(w_a_hi) * PW'(w_b_hi);
            end
        end
    end

    // Recombination: a*b = hh<<2L + (lh+hl)<<L + ll. The exact product fits
    // in PW bits, so no carry out of the sum is lost.
    logic [PW-1:0] w_sum;
    assign w_sum = (r_pp_hh << (2 * LO_W))
                 + ((r_pp_lh + r_pp_hl) << LO_W)
                 + r_pp_ll;

    // ------------------------------------------------------------------
    // Multiplier stages 2..MUL_STAGES: full product delay line
    // ------------------------------------------------------------------
    logic          w_last_vld;
    logic [PW-1:0] w_last_prod;
    logic          w_chain_busy;

    generate
        if (MUL_STAGES == 1) begin : g_single
            assign w_last_vld   = r_v1;
            assign w_last_prod  = w_sum;
            assign w_chain_busy = 1'b0;
        end else begin : g_chain
            logic [MUL_STAGES-2:0] r_vld;
            logic [PW-1:0]         r_prod [MUL_STAGES-1];

            always_ff @(posedge clk_i or negedge rst_ni) begin
                if (!rst_ni) begin
                    r_vld <= '0;
                    for (int k = 0; k < MUL_STAGES - 1; k++) begin
                        r_prod[k] <= '0;
                    end
                end else begin
                    r_vld[0] <= r_v1;
                    if (r_v1) begin
                        r_prod[0] <= w_sum;
                    end
                    for (int k = 1; k < MUL_STAGES - 1; k++) begin
                        r_vld[k] <= r_vld[k-1];
                        if (r_vld[k-1]) begin
                            r_prod[k] <= r_prod[k-1];
                        end
                    end
                end
            end

            assign w_last_vld   = r_vld[MUL_STAGES-2];
            assign w_last_prod  = r_prod[MUL_STAGES-2];
            assign w_chain_busy = |r_vld;
        end
    endgenerate

    // ------------------------------------------------------------------
    // Output register: x_o holds its last value between pulses
    // ------------------------------------------------------------------
    logic [PW-1:0] r_x;
    logic          r_start;

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            r_x     <= '0;
            r_start <= 1'b0;
        end else begin
            r_start <= w_last_vld;
            if (w_last_vld) begin
                r_x <= w_last_prod;
            end
        end
    end

    assign bus.in_ready_o = w_in_ready;
    assign bus.x_o        = r_x;
    assign bus.start_o    = r_start;
    assign bus.count_o    = r_count;
    assign bus.busy_o     = (r_count != '0) || r_v1 || w_chain_busy;

endmodule
`default_nettype wire
